// File: rtl/ui_game_pkg.sv
// ui_game_pkg: shared types and constants for the dice game flow.
//   game_state_t      - six-state game-flow encoding
//   TILE_W / DICE_W   - board position and die value widths
//   LAST_TILE_DEFAULT - goal tile index
//   PLAYER1 / PLAYER2 - encodings of the turn / winner bit
//   dice_legal()      - true for a real die face (1..6)
package ui_game_pkg;

    typedef enum logic [2:0] {
        ST_INTRO     = 3'd0,
        ST_WAIT_DICE = 3'd1,
        ST_STEP      = 3'd2,
        ST_SHOW      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_WIN       = 3'd5
    } game_state_t;

    localparam int   TILE_W            = 4;
    localparam int   DICE_W            = 3;
    localparam int   LAST_TILE_DEFAULT = 15;
    localparam logic PLAYER1           = 1'b0;
    localparam logic PLAYER2           = 1'b1;

    function automatic logic dice_legal(input logic [DICE_W-1:0] v);
        return (v >= DICE_W'(1)) && (v <= DICE_W'(6));
    endfunction

endpackage

// File: rtl/dice_turn_sequencer_if.sv
// dice_turn_sequencer_if: bundle between the game-flow controller and its
// neighbours (dice recognition, menu, UI renderer).
//   master - side that issues start/restart/dice/turn_done and observes state
//   slave  - the sequencer itself
interface dice_turn_sequencer_if;
    import ui_game_pkg::*;

    logic              start_game;
    logic              restart;
    logic              dice_valid;
    logic [DICE_W-1:0] dice_value;
    logic              turn_done;
    logic              is_intro_state;
    logic [TILE_W-1:0] p1_pos;
    logic [TILE_W-1:0] p2_pos;
    logic              turn;
    logic              pos_valid;
    logic              winner_valid;
    logic              winner;
    logic              busy;

    modport master (
        output start_game, restart, dice_valid, dice_value, turn_done,
        input  is_intro_state, p1_pos, p2_pos, turn, pos_valid,
               winner_valid, winner, busy
    );

    modport slave (
        input  start_game, restart, dice_valid, dice_value, turn_done,
        output is_intro_state, p1_pos, p2_pos, turn, pos_valid,
               winner_valid, winner, busy
    );

endinterface

// File: rtl/step_timer.sv
// step_timer: loadable down-counter used for the per-tile step delay and the
// renderer handshake timeout.
//   clk, reset  - clock, synchronous active-high reset (count -> 0)
//   clear_i     - synchronous clear to 0 (idle)
//   load_i      - load load_val_i (takes priority over counting)
//   load_val_i  - value to load (terminal count arrives load_val_i+1 enabled
//                 cycles later)
//   en_i        - count down while high
//   tc_o        - high while enabled and the count is 0
module step_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/dice_turn_sequencer.sv
// dice_turn_sequencer: two-player board-game flow controller.
// Takes a confirmed die roll, walks the active player's token one tile per
// STEP_CYCLES, pulses pos_valid to the renderer, waits for turn_done (or a
// timeout), checks for a winner and passes the turn.
//   clk, reset - clock, synchronous active-high reset
//   bus        - slave side of dice_turn_sequencer_if:
//                in : start_game, restart, dice_valid, dice_value, turn_done
//                out: is_intro_state, p1_pos, p2_pos, turn, pos_valid,
//                     winner_valid, winner, busy
module dice_turn_sequencer
    import ui_game_pkg::*;
#(
    parameter int LAST_TILE    = LAST_TILE_DEFAULT,
    parameter int STEP_CYCLES  = 12500000,
    parameter int DONE_TIMEOUT = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    dice_turn_sequencer_if.slave  bus
);

    localparam int STEP_W = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
    localparam int TMO_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    localparam logic [TILE_W-1:0] LAST_POS = TILE_W'(LAST_TILE);
    localparam logic [TILE_W-1:0] PRE_LAST = TILE_W'(LAST_TILE - 1);

    game_state_t       state_q;
    logic              is_intro_q;
    logic [TILE_W-1:0] p1_pos_q;
    logic [TILE_W-1:0] p2_pos_q;
    logic              turn_q;
    logic              pos_valid_q;
    logic              winner_valid_q;
    logic              winner_q;
    logic              busy_q;
    logic [DICE_W-1:0] steps_left_q;

    logic [TILE_W-1:0] act_pos;
    logic              step_clear, step_load, step_en, step_tc;
    logic              tmo_clear, tmo_load, tmo_en, tmo_tc;

    assign act_pos = (turn_q == PLAYER2) ? p2_pos_q : p1_pos_q;

    // Both timers idle at zero outside the states that use them. The step
    // timer is held loaded in WAIT_DICE so STEP starts with a full interval,
    // and reloads itself on every terminal count. The timeout is held loaded
    // throughout STEP so it starts fresh on the first SHOW cycle.
    always_comb begin
        step_en    = (state_q == ST_STEP);
        step_clear = !((state_q == ST_WAIT_DICE) || (state_q == ST_STEP));
        step_load  = (state_q == ST_WAIT_DICE) || step_tc;
        tmo_en     = (state_q == ST_SHOW);
        tmo_clear  = !((state_q == ST_STEP) || (state_q == ST_SHOW));
        tmo_load   = (state_q == ST_STEP);
    end

    step_timer #(.WIDTH(STEP_W)) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (step_clear),
        .load_i     (step_load),
        .load_val_i (STEP_W'(STEP_CYCLES - 1)),
        .en_i       (step_en),
        .tc_o       (step_tc)
    );

    step_timer #(.WIDTH(TMO_W)) u_done_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (tmo_clear),
        .load_i     (tmo_load),
        .load_val_i (TMO_W'(DONE_TIMEOUT - 1)),
        .en_i       (tmo_en),
        .tc_o       (tmo_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INTRO;
            is_intro_q     <= 1'b1;
            p1_pos_q       <= '0;
            p2_pos_q       <= '0;
            turn_q         <= PLAYER1;
            pos_valid_q    <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= PLAYER1;
            busy_q         <= 1'b0;
            steps_left_q   <= '0;
        end else begin
            case (state_q)
                ST_INTRO: begin
                    p1_pos_q <= '0;
                    p2_pos_q <= '0;
                    turn_q   <= PLAYER1;
                    if (bus.start_game) begin
                        state_q    <= ST_WAIT_DICE;
                        is_intro_q <= 1'b0;
                    end
                end

                ST_WAIT_DICE: begin
                    if (bus.dice_valid && dice_legal(bus.dice_value)) begin
                        steps_left_q <= bus.dice_value;
                        state_q      <= ST_STEP;
                        busy_q       <= 1'b1;
                    end
                end

                ST_STEP: begin
                    if (step_tc) begin
                        // Goal check uses the pre-increment position so the
                        // 4-bit add can never wrap past the goal.
                        if (act_pos == LAST_POS) begin
                            state_q     <= ST_SHOW;
                            pos_valid_q <= 1'b1;
                        end else begin
                            if (turn_q == PLAYER2) begin
                                p2_pos_q <= p2_pos_q + TILE_W'(1);
                            end else begin
                                p1_pos_q <= p1_pos_q + TILE_W'(1);
                            end
                            steps_left_q <= steps_left_q - DICE_W'(1);
                            // Leave on the final increment so pos_valid lands
                            // in the very next cycle; remaining pips are lost
                            // once the goal is reached.
                            if ((steps_left_q == DICE_W'(1)) || (act_pos == PRE_LAST)) begin
                                state_q     <= ST_SHOW;
                                pos_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_SHOW: begin
                    // turn_done in the pulse cycle is a possibly stale level
                    // from the previous move and is deliberately not honoured.
                    if (pos_valid_q) begin
                        pos_valid_q <= 1'b0;
                    end else if (bus.turn_done || tmo_tc) begin
                        state_q <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    busy_q <= 1'b0;
                    if (act_pos == LAST_POS) begin
                        winner_q       <= turn_q;
                        winner_valid_q <= 1'b1;
                        state_q        <= ST_WIN;
                    end else begin
                        turn_q  <= (turn_q == PLAYER1) ? PLAYER2 : PLAYER1;
                        state_q <= ST_WAIT_DICE;
                    end
                end

                ST_WIN: begin
                    if (bus.restart) begin
                        state_q        <= ST_INTRO;
                        is_intro_q     <= 1'b1;
                        p1_pos_q       <= '0;
                        p2_pos_q       <= '0;
                        turn_q         <= PLAYER1;
                        winner_valid_q <= 1'b0;
                        winner_q       <= PLAYER1;
                    end
                end

                default: begin
                    state_q <= ST_INTRO;
                end
            endcase
        end
    end

    assign bus.is_intro_state = is_intro_q;
    assign bus.p1_pos         = p1_pos_q;
    assign bus.p2_pos         = p2_pos_q;
    assign bus.turn           = turn_q;
    assign bus.pos_valid      = pos_valid_q;
    assign bus.winner_valid   = winner_valid_q;
    assign bus.winner         = winner_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_dice_turn_sequencer.sv
// Directed bench for dice_turn_sequencer with STEP_CYCLES=4, DONE_TIMEOUT=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dice_turn_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dice_turn_sequencer_if bus();

    dice_turn_sequencer #(
        .LAST_TILE    (15),
        .STEP_CYCLES  (4),
        .DONE_TIMEOUT (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_dice(input logic [2:0] v);
        bus.dice_valid = 1'b1;
        bus.dice_value = v;
        cyc(1);
        bus.dice_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_intro"},  bus.is_intro_state, 1);
        chk({tag, "_p1"},     bus.p1_pos, 0);
        chk({tag, "_p2"},     bus.p2_pos, 0);
        chk({tag, "_turn"},   bus.turn, 0);
        chk({tag, "_pv"},     bus.pos_valid, 0);
        chk({tag, "_wv"},     bus.winner_valid, 0);
        chk({tag, "_winner"}, bus.winner, 0);
        chk({tag, "_busy"},   bus.busy, 0);
    endtask

    // Full move with a normal handshake, then check the resulting board.
    task automatic roll(input logic [2:0] v, input int e_p1, input int e_p2, input int e_turn);
        int n;
        pulse_dice(v);
        n = 0;
        while (bus.pos_valid !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("roll_pos_valid", bus.pos_valid, 1);
        cyc(1);
        bus.turn_done = 1'b1;
        cyc(1);
        bus.turn_done = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 10) begin
            cyc(1);
            n++;
        end
        chk("roll_busy_low", bus.busy, 0);
        chk("roll_p1", bus.p1_pos, e_p1);
        chk("roll_p2", bus.p2_pos, e_p2);
        chk("roll_turn", bus.turn, e_turn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start_game = 1'b0;
        bus.restart    = 1'b0;
        bus.dice_valid = 1'b0;
        bus.dice_value = 3'd0;
        bus.turn_done  = 1'b0;
        cyc(3);
        check_reset_values("reset");
        reset = 1'b0;

        // Roll in INTRO does nothing
        pulse_dice(3'd3);
        cyc(8);
        chk("intro_dice_p1", bus.p1_pos, 0);
        chk("intro_dice_intro", bus.is_intro_state, 1);
        chk("intro_dice_busy", bus.busy, 0);

        // Start game
        bus.start_game = 1'b1;
        cyc(1);
        bus.start_game = 1'b0;
        chk("start_intro_low", bus.is_intro_state, 0);
        chk("start_p1", bus.p1_pos, 0);
        chk("start_turn", bus.turn, 0);

        // Illegal faces are dropped
        pulse_dice(3'd0);
        chk("dice0_busy", bus.busy, 0);
        pulse_dice(3'd7);
        chk("dice7_busy", bus.busy, 0);
        cyc(2);
        chk("dice07_busy_later", bus.busy, 0);
        chk("dice07_p1", bus.p1_pos, 0);

        // P1 rolls 3: tiles at 4-cycle intervals; extra roll mid-move ignored
        pulse_dice(3'd3);
        chk("r3_busy", bus.busy, 1);
        chk("r3_p1_start", bus.p1_pos, 0);
        cyc(3);
        chk("r3_p1_b3", bus.p1_pos, 0);
        cyc(1);
        chk("r3_p1_b4", bus.p1_pos, 1);
        cyc(1);
        bus.dice_valid = 1'b1;
        bus.dice_value = 3'd2;
        cyc(1);
        bus.dice_valid = 1'b0;
        cyc(1);
        chk("r3_p1_b7", bus.p1_pos, 1);
        cyc(1);
        chk("r3_p1_b8", bus.p1_pos, 2);
        cyc(3);
        chk("r3_p1_b11", bus.p1_pos, 2);
        chk("r3_pv_b11", bus.pos_valid, 0);
        cyc(1);
        chk("r3_p1_b12", bus.p1_pos, 3);
        chk("r3_pv_b12", bus.pos_valid, 1);
        // turn_done during the pulse cycle must not complete the handshake
        bus.turn_done = 1'b1;
        cyc(1);
        bus.turn_done = 1'b0;
        chk("r3_pv_b13", bus.pos_valid, 0);
        chk("r3_busy_b13", bus.busy, 1);
        cyc(1);
        chk("r3_stale_done_busy", bus.busy, 1);
        bus.turn_done = 1'b1;
        cyc(1);
        bus.turn_done = 1'b0;
        chk("r3_check_busy", bus.busy, 1);
        cyc(1);
        chk("r3_done_busy", bus.busy, 0);
        chk("r3_turn", bus.turn, 1);
        chk("r3_p2", bus.p2_pos, 0);
        cyc(6);
        chk("r3_not_queued_busy", bus.busy, 0);
        chk("r3_not_queued_p2", bus.p2_pos, 0);

        // P2 rolls 6, no turn_done: timeout after 20 cycles
        pulse_dice(3'd6);
        cyc(24);
        chk("tmo_p2", bus.p2_pos, 6);
        chk("tmo_pv", bus.pos_valid, 1);
        cyc(19);
        chk("tmo_busy_b43", bus.busy, 1);
        chk("tmo_turn_b43", bus.turn, 1);
        cyc(1);
        chk("tmo_busy_b44", bus.busy, 1);
        chk("tmo_turn_b44", bus.turn, 1);
        cyc(1);
        chk("tmo_busy_b45", bus.busy, 0);
        chk("tmo_turn_b45", bus.turn, 0);

        // Walk P2 up to tile 13
        roll(3'd1, 4, 6, 1);
        roll(3'd6, 4, 12, 0);
        roll(3'd1, 5, 12, 1);
        roll(3'd1, 5, 13, 0);
        roll(3'd1, 6, 13, 1);

        // P2 rolls 6 from 13: saturates at 15 after 2 steps and wins
        pulse_dice(3'd6);
        cyc(4);
        chk("win_p2_b4", bus.p2_pos, 14);
        cyc(4);
        chk("win_p2_b8", bus.p2_pos, 15);
        chk("win_pv_b8", bus.pos_valid, 1);
        cyc(1);
        bus.turn_done = 1'b1;
        cyc(1);
        bus.turn_done = 1'b0;
        chk("win_check_busy", bus.busy, 1);
        chk("win_check_wv", bus.winner_valid, 0);
        cyc(1);
        chk("win_wv", bus.winner_valid, 1);
        chk("win_winner", bus.winner, 1);
        chk("win_busy", bus.busy, 0);
        chk("win_p2", bus.p2_pos, 15);

        // Dice and start_game ignored in WIN
        pulse_dice(3'd3);
        bus.start_game = 1'b1;
        cyc(1);
        bus.start_game = 1'b0;
        cyc(8);
        chk("win_frozen_p1", bus.p1_pos, 6);
        chk("win_frozen_p2", bus.p2_pos, 15);
        chk("win_frozen_turn", bus.turn, 1);
        chk("win_frozen_wv", bus.winner_valid, 1);
        chk("win_frozen_intro", bus.is_intro_state, 0);

        // Restart back to INTRO
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
        chk("restart_intro", bus.is_intro_state, 1);
        chk("restart_p1", bus.p1_pos, 0);
        chk("restart_p2", bus.p2_pos, 0);
        chk("restart_turn", bus.turn, 0);
        chk("restart_wv", bus.winner_valid, 0);

        // Reset in the middle of a move
        bus.start_game = 1'b1;
        cyc(1);
        bus.start_game = 1'b0;
        pulse_dice(3'd6);
        cyc(20);
        chk("mid_p1", bus.p1_pos, 5);
        chk("mid_busy", bus.busy, 1);
        reset = 1'b1;
        cyc(1);
        check_reset_values("midreset");
        reset = 1'b0;
        cyc(6);
        chk("midreset_still_intro", bus.is_intro_state, 1);
        chk("midreset_no_move", bus.p1_pos, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
